// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store path: access sizes, LSU states, byte counts.
package dmem_pkg;

  localparam int unsigned DmemDepth = 16384;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } dmem_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapt,
    StResp
  } dmem_state_e;

  function automatic logic [2:0] byte_count(dmem_size_e sz);
    case (sz)
      SZ_B:    byte_count = 3'd1;
      SZ_H:    byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response channel between the CPU data port and the load/store unit.
interface dmem_lsu_if #(
  parameter int unsigned AW = 16
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_load_align.sv
// Rotates the four bank lanes into access order and sign/zero-extends to 32 bits.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  dmem_size_e  size,
  input  logic        uns,
  input  logic [31:0] bank_rdata,
  output logic [31:0] result
);

  logic [7:0] bytes [4];
  logic       fill;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [1:0] lane;
      lane     = addr_lo + 2'(i);
      bytes[i] = bank_rdata[8*lane +: 8];
    end
    result = {bytes[3], bytes[2], bytes[1], bytes[0]};
    fill   = 1'b0;
    case (size)
      SZ_B: begin
        fill   = ~uns & bytes[0][7];
        result = {{24{fill}}, bytes[0]};
      end
      SZ_H: begin
        fill   = ~uns & bytes[1][7];
        result = {{16{fill}}, bytes[1], bytes[0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store front-end over four byte-wide banks; misaligned accesses
// are split across lanes so every access needs exactly one bank cycle.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = DmemDepth,
  localparam int unsigned AW    = $clog2(DEPTH) + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_lsu_if.slave             bus,
  output logic [4*(AW-2)-1:0]   bank_addr,
  output logic [3:0]            bank_re,
  output logic [3:0]            bank_we,
  output logic [31:0]           bank_wdata,
  input  logic [31:0]           bank_rdata
);

  localparam int unsigned RW    = AW - 2;
  localparam logic [AW:0] Limit = {1'b1, {AW{1'b0}}};

  dmem_state_e   state_q;
  logic          we_q;
  logic          uns_q;
  dmem_size_e    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          req_err;
  logic [AW:0]   req_end;
  logic [2:0]    n_q;
  logic [31:0]   load_data;

  // One bit wider than the address so an access past the top byte is seen, never wrapped.
  always_comb begin
    req_end = {1'b0, bus.req_addr} + (AW+1)'(byte_count(dmem_size_e'(bus.req_size)));
    req_err = (bus.req_size == 2'd3) | (req_end > Limit);
  end

  assign bus.req_ready  = (state_q == StIdle) | ((state_q == StResp) & bus.resp_ready);
  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign n_q = byte_count(size_q);

  always_comb begin
    bank_addr  = {4{addr_q[AW-1:2]}};
    bank_re    = '0;
    bank_we    = '0;
    bank_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] byte_addr;
      int            lane;
      byte_addr = addr_q + AW'(i);
      lane      = int'(byte_addr[1:0]);
      if ((state_q == StIssue) && (i < int'(n_q))) begin
        bank_addr[lane*RW +: RW]  = byte_addr[AW-1:2];
        bank_we[lane]             = we_q;
        bank_re[lane]             = ~we_q;
        bank_wdata[lane*8 +: 8]   = wdata_q[i*8 +: 8];
      end
    end
  end

  dmem_load_align u_load_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .uns        (uns_q),
    .bank_rdata (bank_rdata),
    .result     (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= dmem_size_e'(bus.req_size);
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
      err_q   <= req_err;
      state_q <= req_err ? StResp : StIssue;
    end else begin
      case (state_q)
        StIssue: state_q <= we_q ? StResp : StCapt;
        StCapt: begin
          rdata_q <= load_data;
          state_q <= StResp;
        end
        StResp: if (bus.resp_ready) state_q <= StIdle;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural four-lane bank model.
module tb_dmem_lsu;

  localparam int unsigned DEPTH = 16384;
  localparam int unsigned AW    = 16;
  localparam int unsigned RW    = AW - 2;

  logic              clk;
  logic              rst_n;
  logic [4*RW-1:0]   bank_addr;
  logic [3:0]        bank_re;
  logic [3:0]        bank_we;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata;

  dmem_lsu_if #(.AW(AW)) bus ();

  dmem_lsu #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .bank_addr  (bank_addr),
    .bank_re    (bank_re),
    .bank_we    (bank_we),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [4][DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banks: registered read, write at the clock edge.
  initial bank_rdata = '0;
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bank_re[k]) bank_rdata[8*k +: 8] <= mem[k][bank_addr[k*RW +: RW]];
      if (bank_we[k]) mem[k][bank_addr[k*RW +: RW]] <= bank_wdata[8*k +: 8];
    end
  end

  logic [3:0]    seen_we;
  logic [3:0]    seen_re;
  logic [RW-1:0] seen_row [4];

  always @(negedge clk) begin
    seen_we = seen_we | bank_we;
    seen_re = seen_re | bank_re;
    for (int k = 0; k < 4; k++)
      if (bank_we[k] | bank_re[k]) seen_row[k] = bank_addr[k*RW +: RW];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.resp_ready   = 1'b1;
    @(posedge clk);
    seen_we = '0;
    seen_re = '0;
    for (int k = 0; k < 4; k++) seen_row[k] = '1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          waits;

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    seen_we          = '0;
    seen_re          = '0;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < int'(DEPTH); r++) mem[k][r] = 8'h00;

    #3;
    check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check_eq("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check_eq("rst_strobes", 64'({bank_we, bank_re}), 64'd0);
    check_eq("rst_bank_addr", 64'(bank_addr), 64'd0);
    check_eq("rst_bank_wdata", 64'(bank_wdata), 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store then load.
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, rd, er, lat);
    check_eq("sw_lat", 64'(lat), 64'd2);
    check_eq("sw_err", 64'(er), 64'd0);
    check_eq("sw_rdata", 64'(rd), 64'd0);
    check_eq("sw_we", 64'(seen_we), 64'hF);
    check_eq("sw_re", 64'(seen_re), 64'h0);
    check_eq("sw_row0", 64'(seen_row[0]), 64'd4);
    check_eq("sw_row3", 64'(seen_row[3]), 64'd4);
    check_eq("sw_mem", 64'({mem[3][4], mem[2][4], mem[1][4], mem[0][4]}), 64'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    check_eq("lw_lat", 64'(lat), 64'd3);
    check_eq("lw_data", 64'(rd), 64'hDEADBEEF);
    check_eq("lw_err", 64'(er), 64'd0);
    check_eq("lw_re", 64'(seen_re), 64'hF);

    // Misaligned word across two rows.
    do_req(1'b1, 2'd2, 1'b0, 16'h0003, 32'h11223344, rd, er, lat);
    check_eq("msw_l3r0", 64'(mem[3][0]), 64'h44);
    check_eq("msw_l0r1", 64'(mem[0][1]), 64'h33);
    check_eq("msw_l1r1", 64'(mem[1][1]), 64'h22);
    check_eq("msw_l2r1", 64'(mem[2][1]), 64'h11);
    check_eq("msw_row3", 64'(seen_row[3]), 64'd0);
    check_eq("msw_row0", 64'(seen_row[0]), 64'd1);
    do_req(1'b0, 2'd2, 1'b0, 16'h0003, 32'h0, rd, er, lat);
    check_eq("mlw_data", 64'(rd), 64'h11223344);

    // Byte and half extension.
    do_req(1'b1, 2'd0, 1'b0, 16'h0005, 32'h00000080, rd, er, lat);
    check_eq("sb_we", 64'(seen_we), 64'b0010);
    do_req(1'b0, 2'd0, 1'b0, 16'h0005, 32'h0, rd, er, lat);
    check_eq("lb_signed", 64'(rd), 64'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 16'h0005, 32'h0, rd, er, lat);
    check_eq("lb_unsigned", 64'(rd), 64'h00000080);
    do_req(1'b1, 2'd1, 1'b0, 16'h0005, 32'h00008001, rd, er, lat);
    check_eq("sh_we", 64'(seen_we), 64'b0110);
    do_req(1'b0, 2'd1, 1'b0, 16'h0005, 32'h0, rd, er, lat);
    check_eq("lh_signed", 64'(rd), 64'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 16'h0005, 32'h0, rd, er, lat);
    check_eq("lh_unsigned", 64'(rd), 64'h00008001);

    // Top-of-memory boundary and illegal size.
    do_req(1'b0, 2'd1, 1'b0, 16'hFFFF, 32'h0, rd, er, lat);
    check_eq("top_h_lat", 64'(lat), 64'd1);
    check_eq("top_h_err", 64'(er), 64'd1);
    check_eq("top_h_rdata", 64'(rd), 64'd0);
    check_eq("top_h_strb", 64'({seen_we, seen_re}), 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 16'h0000, 32'h0, rd, er, lat);
    check_eq("sz3_lat", 64'(lat), 64'd1);
    check_eq("sz3_err", 64'(er), 64'd1);
    check_eq("sz3_rdata", 64'(rd), 64'd0);
    check_eq("sz3_strb", 64'({seen_we, seen_re}), 64'd0);
    do_req(1'b1, 2'd2, 1'b0, 16'hFFFD, 32'h12345678, rd, er, lat);
    check_eq("top_w_err", 64'(er), 64'd1);
    check_eq("top_w_strb", 64'({seen_we, seen_re}), 64'd0);
    do_req(1'b1, 2'd0, 1'b0, 16'hFFFF, 32'h000000A5, rd, er, lat);
    check_eq("top_b_err", 64'(er), 64'd0);
    check_eq("top_b_mem", 64'(mem[3][DEPTH-1]), 64'hA5);
    do_req(1'b0, 2'd0, 1'b1, 16'hFFFF, 32'h0, rd, er, lat);
    check_eq("top_b_load", 64'(rd), 64'h000000A5);

    // Response backpressure, then accept in the handshake cycle.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd1;
    bus.req_unsigned = 1'b1;
    bus.req_addr     = 16'h0005;
    bus.resp_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    waits = 0;
    while (!bus.resp_valid && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", 64'(bus.resp_valid), 64'd1);
      check_eq("bp_rdata", 64'(bus.resp_rdata), 64'h00008001);
      check_eq("bp_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.resp_ready   = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    #1;
    check_eq("hs_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    check_eq("hs_accepted", 64'(bus.resp_valid), 64'd0);
    check_eq("hs_issue_re", 64'(bank_re), 64'b0010);
    @(negedge clk);
    bus.req_valid = 1'b0;
    waits = 0;
    while (!bus.resp_valid && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check_eq("hs_rdata", 64'(bus.resp_rdata), 64'h00000001);

    // Reset while a load is in ISSUE.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_addr     = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("rsti_re_before", 64'(bank_re), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rsti_strobes", 64'({bank_we, bank_re}), 64'd0);
    check_eq("rsti_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rsti_no_resp", 64'(bus.resp_valid), 64'd0);
      check_eq("rsti_idle", 64'(bus.req_ready), 64'd1);
    end
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    check_eq("post_rst_load", 64'(rd), 64'hDEADBEEF);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
